packet_tx_fifo: RTL and testbench

PACKET_TX_FIFO -- requirements
Module: packet_tx_fifo

---
 rtl/packet_tx_pkg.sv | 22 ++
 rtl/packet_tx_fifo_buf.sv | 61 ++++++
 rtl/packet_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_packet_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_tx_pkg.sv
// Shared definitions for the packet transmitter slice.
//   tx_state_t            : transmitter FSM states
//   HDR_REQ_DEFAULT       : default sample-request header payload
//   HDR_UNDERRUN_DEFAULT  : default underrun header payload
//   pkt_width()           : packet width (valid bit + payload)
package packet_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_GAP,
    ST_DATA
  } tx_state_t;

  localparam logic [39:0] HDR_REQ_DEFAULT      = 40'h07_0000_0000;
  localparam logic [39:0] HDR_UNDERRUN_DEFAULT = 40'h0f_0000_0000;

  function automatic int unsigned pkt_width(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/packet_tx_fifo_buf.sv
// Payload FIFO for the packet transmitter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push_data  : word written on push
//   push       : write request (ignored while full)
//   pop        : read request (ignored while empty)
//   pop_data   : head-of-queue word (valid while !empty)
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
module packet_tx_fifo_buf #(
  parameter int unsigned DATA_W = 40,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     push,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/packet_tx_fifo.sv
// Serial packet transmitter with payload FIFO.
// Each req_tick in IDLE starts a slot: header packet, GAP_CYCLES idle
// bits, then a data packet popped from the FIFO (all zeros if empty).
// A packet is a valid bit followed by the payload, MSB first.
// Optional macro PACKET_TX_PARITY_EN appends an even-parity bit to each
// packet.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready : payload queue input (in_ready = !full)
//   req_mode      : send sample-request header
//   req_underrun  : send underrun header (priority over req_mode)
//   req_tick      : slot start strobe
//   sout          : serial output
//   data_loss     : pulse, a word was offered while full and dropped
//   tick_missed   : pulse, req_tick arrived while busy
//   busy          : slot in progress
//   fifo_level    : FIFO occupancy
module packet_tx_fifo
  import packet_tx_pkg::*;
#(
  parameter int unsigned         DATA_W       = 40,
  parameter int unsigned         DEPTH        = 4,
  parameter int unsigned         GAP_CYCLES   = 3,
  parameter logic [DATA_W-1:0]   HDR_REQ      = DATA_W'(HDR_REQ_DEFAULT),
  parameter logic [DATA_W-1:0]   HDR_UNDERRUN = DATA_W'(HDR_UNDERRUN_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   req_mode,
  input  logic                   req_underrun,
  input  logic                   req_tick,
  output logic                   sout,
  output logic                   data_loss,
  output logic                   tick_missed,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned PKT_W = pkt_width(DATA_W);
`ifdef PACKET_TX_PARITY_EN
  localparam int unsigned SR_W  = PKT_W + 1;
`else
  localparam int unsigned SR_W  = PKT_W;
`endif
  localparam int unsigned CNT_MAX = (SR_W > GAP_CYCLES) ? SR_W : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SR_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_CYCLES - 1);

  function automatic logic [SR_W-1:0] make_frame(input logic [DATA_W-1:0] payload);
`ifdef PACKET_TX_PARITY_EN
    return {1'b1, payload, ^{1'b1, payload}};
`else
    return {1'b1, payload};
`endif
  endfunction

  tx_state_t         state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              data_loss_q, tick_missed_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [SR_W-1:0]   hdr_frame, data_frame;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  packet_tx_fifo_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push_data (in_data),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    hdr_frame = '0;
    if (req_underrun)  hdr_frame = make_frame(HDR_UNDERRUN);
    else if (req_mode) hdr_frame = make_frame(HDR_REQ);
  end

  assign data_frame = fifo_empty ? '0 : make_frame(fifo_head);

  // The shift register drains to zero as it shifts, so GAP and IDLE
  // output zeros without a separate mux on sout.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_tick) begin
          state_d = ST_HDR;
          sr_d    = hdr_frame;
          cnt_d   = '0;
        end
      end
      ST_HDR: begin
        sr_d  = {sr_q[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d  = ST_DATA;
            sr_d     = data_frame;
            fifo_pop = 1'b1;
          end else begin
            state_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_GAP) begin
          state_d  = ST_DATA;
          cnt_d    = '0;
          sr_d     = data_frame;
          fifo_pop = 1'b1;
        end
      end
      ST_DATA: begin
        sr_d  = {sr_q[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      data_loss_q   <= 1'b0;
      tick_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      data_loss_q   <= in_valid && fifo_full;
      tick_missed_q <= req_tick && (state_q != ST_IDLE);
    end
  end

  assign sout        = sr_q[SR_W-1];
  assign busy        = (state_q != ST_IDLE);
  assign data_loss   = data_loss_q;
  assign tick_missed = tick_missed_q;

endmodule

// File: tb/tb_packet_tx_fifo.sv
module tb_packet_tx_fifo;

  localparam int DATA_W     = 40;
  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 3;
  localparam int LVL_W      = $clog2(DEPTH) + 1;
  localparam logic [DATA_W-1:0] HDR_R = 40'h07_0000_0000;
  localparam logic [DATA_W-1:0] HDR_U = 40'h0f_0000_0000;
`ifdef PACKET_TX_PARITY_EN
  localparam int LEN = DATA_W + 2;
`else
  localparam int LEN = DATA_W + 1;
`endif
  localparam int SLOT = 2 * LEN + GAP_CYCLES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              req_mode = 1'b0;
  logic              req_underrun = 1'b0;
  logic              req_tick = 1'b0;
  logic              sout, data_loss, tick_missed, busy;
  logic [LVL_W-1:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] model [$];

  always #5 clk = ~clk;

  packet_tx_fifo #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .GAP_CYCLES   (GAP_CYCLES),
    .HDR_REQ      (HDR_R),
    .HDR_UNDERRUN (HDR_U)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .req_mode     (req_mode),
    .req_underrun (req_underrun),
    .req_tick     (req_tick),
    .sout         (sout),
    .data_loss    (data_loss),
    .tick_missed  (tick_missed),
    .busy         (busy),
    .fifo_level   (fifo_level)
  );

  // Packet as transmitted, right-aligned: valid bit, payload, optional parity.
  function automatic logic [255:0] frame_bits(input logic v, input logic [DATA_W-1:0] p);
    logic [255:0] f;
    f = 256'({v, p});
`ifdef PACKET_TX_PARITY_EN
    f = (f << 1) | 256'($countones({v, p}) % 2);
`endif
    return f;
  endfunction

  task automatic push_word(input logic [DATA_W-1:0] w);
    logic acc;
    acc = (model.size() < DEPTH);
    @(negedge clk);
    n_checks++;
    if (in_ready !== acc) begin
      n_fail++; $display("FAIL push_in_ready: got %b expected %b", in_ready, acc);
    end
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    if (acc) model.push_back(w);
    n_checks++;
    if (data_loss !== !acc) begin
      n_fail++; $display("FAIL push_data_loss: got %b expected %b", data_loss, !acc);
    end
    n_checks++;
    if (fifo_level !== LVL_W'(model.size())) begin
      n_fail++; $display("FAIL push_level: got %0d expected %0d", fifo_level, model.size());
    end
    @(negedge clk);
    n_checks++;
    if (data_loss !== 1'b0) begin
      n_fail++; $display("FAIL data_loss_width: got %b expected 0", data_loss);
    end
  endtask

  // Drives one slot and compares the whole serial stream against the model.
  task automatic run_slot(input logic mode, input logic und, input int miss_at);
    logic [255:0] exp, obs, hdr, dat;
    int n, pre, post;
    pre  = model.size();
    post = (pre > 0) ? pre - 1 : 0;
    if (und)       hdr = frame_bits(1'b1, HDR_U);
    else if (mode) hdr = frame_bits(1'b1, HDR_R);
    else           hdr = '0;
    dat = (pre > 0) ? frame_bits(1'b1, model[0]) : '0;
    exp = (hdr << (LEN + GAP_CYCLES)) | dat;
    @(negedge clk);
    req_tick = 1'b1; req_mode = mode; req_underrun = und;
    @(negedge clk);
    req_tick = 1'b0;
    n_checks++;
    if (tick_missed !== 1'b0) begin
      n_fail++; $display("FAIL idle_tick_missed: got %b expected 0", tick_missed);
    end
    obs = '0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      obs = {obs[254:0], sout};
      if (n == LEN + GAP_CYCLES - 1) begin
        n_checks++;
        if (fifo_level !== LVL_W'(pre)) begin
          n_fail++; $display("FAIL level_pre_data: got %0d expected %0d", fifo_level, pre);
        end
      end
      if (n == LEN + GAP_CYCLES) begin
        n_checks++;
        if (fifo_level !== LVL_W'(post)) begin
          n_fail++; $display("FAIL level_post_data: got %0d expected %0d", fifo_level, post);
        end
      end
      if (miss_at >= 0) begin
        if (n == miss_at) req_tick = 1'b1;
        if (n == miss_at + 1) begin
          req_tick = 1'b0;
          n_checks++;
          if (tick_missed !== 1'b1) begin
            n_fail++; $display("FAIL tick_missed_pulse: got %b expected 1", tick_missed);
          end
        end
        if (n == miss_at + 2) begin
          n_checks++;
          if (tick_missed !== 1'b0) begin
            n_fail++; $display("FAIL tick_missed_width: got %b expected 0", tick_missed);
          end
        end
      end
      n++;
      @(negedge clk);
    end
    req_tick = 1'b0;
    if (pre > 0) void'(model.pop_front());
    n_checks++;
    if (n != SLOT) begin
      n_fail++; $display("FAIL slot_length: got %0d expected %0d", n, SLOT);
    end
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL slot_stream: got %h expected %h", obs, exp);
    end
    n_checks++;
    if (sout !== 1'b0) begin
      n_fail++; $display("FAIL idle_sout: got %b expected 0", sout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sout, data_loss, tick_missed, busy, in_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00001", {sout, data_loss, tick_missed, busy, in_ready});
    end
    n_checks++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_req_header();
    run_slot(1'b1, 1'b0, -1);
  endtask

  task automatic test_data_packet();
    push_word(40'hAA_55AA_55AA);
    run_slot(1'b0, 1'b0, -1);
  endtask

  task automatic test_underrun_priority();
    run_slot(1'b1, 1'b1, -1);
  endtask

  task automatic test_tick_missed();
    run_slot(1'b1, 1'b0, 10);
  endtask

  task automatic test_reset_mid_slot();
    int busy_cnt;
    push_word(40'h12_3456_789A);
    push_word(40'hFE_DCBA_9876);
    @(negedge clk);
    req_tick = 1'b1; req_mode = 1'b1; req_underrun = 1'b0;
    @(negedge clk);
    req_tick = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sout, busy, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL async_reset_outputs: got %b expected 001", {sout, busy, in_ready});
    end
    n_checks++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL async_reset_level: got %0d expected 0", fifo_level);
    end
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 0) begin
      n_fail++; $display("FAIL busy_after_reset: got %0d expected 0", busy_cnt);
    end
    push_word(40'h5A_A5C3_3C0F);
    run_slot(1'b0, 1'b0, -1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) push_word(DATA_W'({$urandom(), $urandom()}));
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready);
    end
    n_checks++;
    if (fifo_level !== LVL_W'(DEPTH)) begin
      n_fail++; $display("FAIL full_level: got %0d expected %0d", fifo_level, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int k;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) push_word(DATA_W'({$urandom(), $urandom()}));
      run_slot(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    while (model.size() > 0) run_slot(1'b0, 1'b0, -1);
    n_checks++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL drained_level: got %0d expected 0", fifo_level);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_req_header();
    test_data_packet();
    test_underrun_priority();
    test_tick_missed();
    test_reset_mid_slot();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
